// File: rtl/serial_link_bringup_pkg.sv
// Shared types and constants for the serial link bring-up controller.
// CTRL values are built from the link's CTRL bit positions.
package serial_link_bringup_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_RST,
    S_WR_REL,
    S_RD_ISO,
    S_GAP_ISO,
    S_WR_OPEN,
    S_RD_OPEN,
    S_GAP_OPEN,
    S_DONE,
    S_ERROR
  } state_e;

  localparam int CtrlClkEna    = 0;
  localparam int CtrlResetN    = 1;
  localparam int CtrlAxiInIso  = 8;
  localparam int CtrlAxiOutIso = 9;

  localparam logic [15:0] CtrlReset = 16'((1 << CtrlAxiOutIso)
    | (1 << CtrlAxiInIso) | (1 << CtrlClkEna));
  localparam logic [15:0] CtrlRelease = CtrlReset
    | 16'(1 << CtrlResetN);
  localparam logic [15:0] CtrlOpen = 16'((1 << CtrlResetN)
    | (1 << CtrlClkEna));

  localparam logic [1:0] IsoMask = 2'b11;

endpackage

// File: rtl/serial_link_bringup_timer.sv
// Poll-gap down-counter and per-phase poll counter.
// Poll counter exists only with SERIAL_LINK_BRINGUP_TIMEOUT_EN.
module serial_link_bringup_timer #(
  parameter int PollGap      = 4,
  parameter int TimeoutPolls = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic load_i,
  input  logic tick_i,
  output logic gap_done_o,
  output logic timeout_o
);

  localparam int GW = (PollGap > 1) ? $clog2(PollGap) : 1;

  logic [GW-1:0] r_gap;

  // Loaded with PollGap-1 so GAP lasts exactly PollGap cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_gap <= '0;
    end else if (load_i) begin
      r_gap <= GW'(PollGap - 1);
    end else if (tick_i && (r_gap != '0)) begin
      r_gap <= r_gap - 1'b1;
    end
  end

  assign gap_done_o = (r_gap == '0);

`ifdef SERIAL_LINK_BRINGUP_TIMEOUT_EN
  localparam int PW = $clog2(TimeoutPolls + 1);

  logic [PW-1:0] r_polls;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_polls <= '0;
    end else if (load_i) begin
      r_polls <= r_polls + 1'b1;
    end
  end

  // True while the read now completing is the last one allowed.
  assign timeout_o = (r_polls == PW'(TimeoutPolls - 1));
`else
  logic w_unused_clr;
  assign w_unused_clr = clr_i | (TimeoutPolls < 1);
  assign timeout_o    = 1'b0;
`endif

endmodule

// File: rtl/serial_link_bringup_ctrl.sv
// Config-bus master running the serial link bring-up sequence.
// Poll timeout enabled by SERIAL_LINK_BRINGUP_TIMEOUT_EN.
module serial_link_bringup_ctrl
  import serial_link_bringup_pkg::*;
#(
  parameter int RegAddrWidth = 32,
  parameter int RegDataWidth = 32,
  parameter logic [RegAddrWidth-1:0] CtrlAddr     = 'h0,
  parameter logic [RegAddrWidth-1:0] IsolatedAddr = 'h4,
  parameter int PollGap      = 4,
  parameter int TimeoutPolls = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic [RegAddrWidth-1:0]   reg_addr_o,
  output logic                      reg_write_o,
  output logic [RegDataWidth-1:0]   reg_wdata_o,
  output logic [RegDataWidth/8-1:0] reg_wstrb_o,
  output logic                      reg_valid_o,
  input  logic [RegDataWidth-1:0]   reg_rdata_i,
  input  logic                      reg_ready_i,
  input  logic                      reg_error_i
);

  localparam logic [RegDataWidth/8-1:0] StrbAll = '1;
  localparam logic [RegDataWidth-1:0] WdReset   = RegDataWidth'(CtrlReset);
  localparam logic [RegDataWidth-1:0] WdRelease = RegDataWidth'(CtrlRelease);
  localparam logic [RegDataWidth-1:0] WdOpen    = RegDataWidth'(CtrlOpen);

  state_e r_state;
  logic   w_xfer;
  logic   w_is_rd;
  logic   w_hit;
  logic   w_abort;
  logic   w_gap_done;
  logic   w_timeout;
  logic   w_unused_rdata;

  assign w_is_rd = (r_state == S_RD_ISO) || (r_state == S_RD_OPEN);
  assign w_xfer  = reg_ready_i && (w_is_rd
    || (r_state inside {S_WR_RST, S_WR_REL, S_WR_OPEN}));
  assign w_hit   = (r_state == S_RD_ISO)
    ? (reg_rdata_i[1:0] == IsoMask)
    : (reg_rdata_i[1:0] == 2'b00);
  assign w_abort = w_xfer
    && (reg_error_i || (w_is_rd && !w_hit && w_timeout));
  assign w_unused_rdata = ^reg_rdata_i[RegDataWidth-1:2];

  serial_link_bringup_timer #(
    .PollGap      (PollGap),
    .TimeoutPolls (TimeoutPolls)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (w_xfer && (r_state inside {S_WR_REL, S_WR_OPEN})),
    .load_i     (w_xfer && w_is_rd),
    .tick_i     (r_state inside {S_GAP_ISO, S_GAP_OPEN}),
    .gap_done_o (w_gap_done),
    .timeout_o  (w_timeout)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      reg_valid_o <= 1'b0;
      reg_write_o <= 1'b0;
      reg_addr_o  <= '0;
      reg_wdata_o <= '0;
      reg_wstrb_o <= '0;
    end else if (w_abort) begin
      r_state     <= S_ERROR;
      reg_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      err_o       <= 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start_i) begin
            r_state     <= S_WR_RST;
            reg_valid_o <= 1'b1;
            reg_write_o <= 1'b1;
            reg_addr_o  <= CtrlAddr;
            reg_wdata_o <= WdReset;
            reg_wstrb_o <= StrbAll;
            busy_o      <= 1'b1;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
          end
        end
        S_WR_RST: begin
          if (reg_ready_i) begin
            r_state     <= S_WR_REL;
            reg_wdata_o <= WdRelease;
          end
        end
        S_WR_REL, S_WR_OPEN: begin
          if (reg_ready_i) begin
            r_state     <= (r_state == S_WR_REL) ? S_RD_ISO : S_RD_OPEN;
            reg_write_o <= 1'b0;
            reg_addr_o  <= IsolatedAddr;
            reg_wdata_o <= '0;
            reg_wstrb_o <= '0;
          end
        end
        S_RD_ISO: begin
          if (reg_ready_i) begin
            if (w_hit) begin
              r_state     <= S_WR_OPEN;
              reg_write_o <= 1'b1;
              reg_addr_o  <= CtrlAddr;
              reg_wdata_o <= WdOpen;
              reg_wstrb_o <= StrbAll;
            end else begin
              r_state     <= S_GAP_ISO;
              reg_valid_o <= 1'b0;
            end
          end
        end
        S_RD_OPEN: begin
          if (reg_ready_i) begin
            reg_valid_o <= 1'b0;
            if (w_hit) begin
              r_state <= S_DONE;
              busy_o  <= 1'b0;
              done_o  <= 1'b1;
            end else begin
              r_state <= S_GAP_OPEN;
            end
          end
        end
        S_GAP_ISO, S_GAP_OPEN: begin
          if (w_gap_done) begin
            r_state     <= (r_state == S_GAP_ISO) ? S_RD_ISO : S_RD_OPEN;
            reg_valid_o <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_link_bringup_ctrl.sv
// Scoreboard bench for serial_link_bringup_ctrl.
// Timeout case runs only with SERIAL_LINK_BRINGUP_TIMEOUT_EN.
module tb_serial_link_bringup_ctrl;

  localparam int PG = 4;
`ifdef SERIAL_LINK_BRINGUP_TIMEOUT_EN
  localparam int TP = 4;
`else
  localparam int TP = 256;
`endif

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        busy_o, done_o, err_o;
  logic [31:0] reg_addr_o;
  logic        reg_write_o;
  logic [31:0] reg_wdata_o;
  logic [3:0]  reg_wstrb_o;
  logic        reg_valid_o;
  logic [31:0] reg_rdata_i = '0;
  logic        reg_ready_i = 1'b0;
  logic        reg_error_i = 1'b0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  exp_t exp_q[$];
  logic [1:0] rd_q[$];
  logic [1:0] rd_dflt = 2'b00;
  int wait_cycles = 0;
  int waited = 0;
  int err_at = -1;
  int xfer_idx = 0;
  int vcnt = 0;

  serial_link_bringup_ctrl #(
    .RegAddrWidth (32),
    .RegDataWidth (32),
    .CtrlAddr     (32'h0),
    .IsolatedAddr (32'h4),
    .PollGap      (PG),
    .TimeoutPolls (TP)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .reg_addr_o  (reg_addr_o),
    .reg_write_o (reg_write_o),
    .reg_wdata_o (reg_wdata_o),
    .reg_wstrb_o (reg_wstrb_o),
    .reg_valid_o (reg_valid_o),
    .reg_rdata_i (reg_rdata_i),
    .reg_ready_i (reg_ready_i),
    .reg_error_i (reg_error_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string n, input logic [63:0] act,
                       input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", n, act, req);
    end
  endtask

  task automatic push_w(input logic [31:0] d);
    exp_t e;
    e.w = 1'b1; e.a = 32'h0; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic push_r();
    exp_t e;
    e.w = 1'b0; e.a = 32'h4; e.d = 32'h0;
    exp_q.push_back(e);
  endtask

  task automatic pulse(output int s);
    @(negedge clk);
    start_i = 1'b1;
    s = cyc;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_end(output int c);
    int k;
    for (k = 0; k < 2000; k++) begin
      if (done_o || err_o) break;
      @(negedge clk);
    end
    if (k == 2000) check("end_timeout", 64'd0, 64'd1);
    c = cyc;
  endtask

  // Responder: drives ready/rdata/error at the falling edge.
  always @(negedge clk) begin
    reg_ready_i = 1'b0;
    reg_error_i = 1'b0;
    reg_rdata_i = '0;
    if (reg_valid_o) begin
      if (waited < wait_cycles) begin
        waited++;
      end else begin
        waited = 0;
        reg_ready_i = 1'b1;
        if (!reg_write_o)
          reg_rdata_i = {30'd0, (rd_q.size() > 0) ? rd_q.pop_front() : rd_dflt};
        if (xfer_idx == err_at) reg_error_i = 1'b1;
        xfer_idx++;
      end
    end
  end

  // Monitor: pops the scoreboard on every completed request.
  initial begin
    logic        pv;
    logic        hp;
    logic        sw;
    logic [31:0] sa, sd;
    logic [3:0]  ss;
    int          lrd;
    exp_t        e;
    pv = 1'b0; hp = 1'b0; lrd = -1;
    sw = 1'b0; sa = '0; sd = '0; ss = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst_i) begin
        pv = 1'b0; hp = 1'b0; lrd = -1;
      end else begin
        if (reg_valid_o) begin
          vcnt++;
          if (!pv && !reg_write_o && lrd >= 0)
            check("gap_spacing", 64'(cyc - lrd), 64'(PG + 1));
          if (hp)
            check("stable", {reg_write_o, reg_addr_o, reg_wdata_o[26:0], reg_wstrb_o},
                  {sw, sa, sd[26:0], ss});
          if (reg_ready_i) begin
            hp = 1'b0;
            if (exp_q.size() == 0) begin
              check("unexpected_req", {reg_write_o, reg_addr_o}, 64'hDEAD);
            end else begin
              e = exp_q.pop_front();
              check("req_write", 64'(reg_write_o), 64'(e.w));
              check("req_addr", 64'(reg_addr_o), 64'(e.a));
              if (e.w) check("req_wdata", 64'(reg_wdata_o), 64'(e.d));
              check("req_wstrb", 64'(reg_wstrb_o), e.w ? 64'hF : 64'h0);
            end
            lrd = reg_write_o ? -1 : cyc;
          end else begin
            hp = 1'b1;
            sw = reg_write_o; sa = reg_addr_o;
            sd = reg_wdata_o; ss = reg_wstrb_o;
          end
        end
        pv = reg_valid_o;
      end
    end
  end

  initial begin
    int s, c;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_valid", 64'(reg_valid_o), 64'd0);
    check("rst_fields", {reg_write_o, reg_addr_o, reg_wdata_o[26:0], reg_wstrb_o}, 64'd0);
    rst_i = 1'b0;

    // Zero-wait run: 3 then 0.
    rd_q = '{2'b11, 2'b00};
    xfer_idx = 0;
    push_w(32'h0301); push_w(32'h0303); push_r(); push_w(32'h0003); push_r();
    pulse(s);
    check("t1_valid_rise", 64'(reg_valid_o), 64'd1);
    check("t1_busy_rise", 64'(busy_o), 64'd1);
    wait_end(c);
    check("t1_latency", 64'(c - s), 64'd6);
    check("t1_done", {done_o, err_o, busy_o}, 3'b100);
    check("t1_q_empty", 64'(exp_q.size()), 64'd0);

    // Isolation polls: 01, 01, 11, then open.
    rd_q = '{2'b01, 2'b01, 2'b11, 2'b00};
    xfer_idx = 0;
    push_w(32'h0301); push_w(32'h0303);
    push_r(); push_r(); push_r();
    push_w(32'h0003); push_r();
    pulse(s);
    check("t2_done_cleared", 64'(done_o), 64'd0);
    wait_end(c);
    check("t2_done", {done_o, err_o, busy_o}, 3'b100);
    check("t2_xfers", 64'(xfer_idx), 64'd7);
    check("t2_q_empty", 64'(exp_q.size()), 64'd0);

    // Bus error on WR_REL completion.
    rd_q = '{};
    xfer_idx = 0;
    err_at = 1;
    push_w(32'h0301); push_w(32'h0303);
    pulse(s);
    wait_end(c);
    repeat (20) @(negedge clk);
    check("t3_flags", {done_o, err_o, busy_o, reg_valid_o}, 4'b0100);
    check("t3_xfers", 64'(xfer_idx), 64'd2);
    check("t3_q_empty", 64'(exp_q.size()), 64'd0);
    err_at = -1;

    // Slow responder: 7 wait cycles per request.
    rd_q = '{2'b11, 2'b00};
    xfer_idx = 0;
    wait_cycles = 7;
    vcnt = 0;
    push_w(32'h0301); push_w(32'h0303); push_r(); push_w(32'h0003); push_r();
    pulse(s);
    wait_end(c);
    repeat (5) @(negedge clk);
    check("t4_flags", {done_o, err_o, busy_o}, 3'b100);
    check("t4_valid_cycles", 64'(vcnt), 64'd40);
    check("t4_xfers", 64'(xfer_idx), 64'd5);
    check("t4_q_empty", 64'(exp_q.size()), 64'd0);
    wait_cycles = 0;

`ifdef SERIAL_LINK_BRINGUP_TIMEOUT_EN
    // RD_OPEN never clears: exactly TP reads then error.
    rd_q = '{2'b11};
    rd_dflt = 2'b10;
    xfer_idx = 0;
    push_w(32'h0301); push_w(32'h0303); push_r(); push_w(32'h0003);
    for (int i = 0; i < TP; i++) push_r();
    pulse(s);
    wait_end(c);
    repeat (20) @(negedge clk);
    check("t5_flags", {done_o, err_o, busy_o}, 3'b010);
    check("t5_xfers", 64'(xfer_idx), 64'(4 + TP));
    check("t5_q_empty", 64'(exp_q.size()), 64'd0);
`endif

    // Reset in the middle of RD_ISO, then rerun.
    rd_q = '{};
    rd_dflt = 2'b01;
    xfer_idx = 0;
    push_w(32'h0301); push_w(32'h0303);
    pulse(s);
    for (int k = 0; k < 50; k++) begin
      if (reg_valid_o && !reg_write_o) break;
      @(negedge clk);
    end
    check("t6_in_rd_iso", {reg_valid_o, reg_write_o, reg_addr_o}, {2'b10, 32'h4});
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("t6_valid_drop", 64'(reg_valid_o), 64'd0);
    check("t6_busy_drop", 64'(busy_o), 64'd0);
    check("t6_q_empty", 64'(exp_q.size()), 64'd0);
    rd_dflt = 2'b00;
    rd_q = '{2'b11, 2'b00};
    xfer_idx = 0;
    push_w(32'h0301); push_w(32'h0303); push_r(); push_w(32'h0003); push_r();
    pulse(s);
    wait_end(c);
    check("t6_rerun_latency", 64'(c - s), 64'd6);
    check("t6_rerun_done", {done_o, err_o, busy_o}, 3'b100);
    check("t6_rerun_q_empty", 64'(exp_q.size()), 64'd0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
